seq_fixed_mul: RTL

Sequential signed fixed-point multiplier. It is the inverse-operation companion to the fixed-point divider and uses the same Q-format convention: WIDTH total bits, BIN_POS fractional bits. It sits beside the divider in the arithmetic datapath and uses a start/ready/complete handshake. The shift-add core retires one operand bit per cycle, trading latency for area.

---
 rtl/fixed_arith_pkg.sv | 36 +++
 rtl/seq_fixed_mul.sv | 112 +++++++++++
 2 files changed

// File: rtl/fixed_arith_pkg.sv
// Shared fixed-point arithmetic definitions for the multiplier and divider:
// sequencer states, counter sizing and saturation limit helpers.
package fixed_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } fix_state_e;

  // Widest datapath the limit helpers can describe.
  localparam int unsigned MAX_W = 64;

  // Bits needed to count 0..w inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Largest positive two's complement value of width w, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i + 1 < w; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Most negative two's complement value of width w, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    r[w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/seq_fixed_mul.sv
// Sequential signed fixed-point multiplier, shift-add, one multiplier bit
// per cycle. Operands and result are signed Q(DATA_WIDTH-BIN_POS).BIN_POS.
// Optional build macro SEQ_FIXED_MUL_SATURATE_EN clamps prod on overflow;
// otherwise prod is the wrapped low DATA_WIDTH bits.
module seq_fixed_mul
  import fixed_arith_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BIN_POS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  output logic                  complete,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] prod,
  output logic                  overflow
);

  localparam int unsigned W2 = 2 * DATA_WIDTH;
  localparam int unsigned CW = cnt_width(DATA_WIDTH);

`ifdef SEQ_FIXED_MUL_SATURATE_EN
  localparam logic [MAX_W-1:0]      SAT_MAX_FULL = sat_max(DATA_WIDTH);
  localparam logic [MAX_W-1:0]      SAT_MIN_FULL = sat_min(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX      = SAT_MAX_FULL[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] SAT_MIN      = SAT_MIN_FULL[DATA_WIDTH-1:0];
`endif

  fix_state_e            state;
  logic [W2-1:0]         acc;
  logic [W2-1:0]         mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [CW-1:0]         cnt;
  logic                  sign_q;

  logic [DATA_WIDTH-1:0] abs_a;
  logic [DATA_WIDTH-1:0] abs_b;
  logic [W2-1:0]         signed_full;
  logic [W2-1:0]         shifted;
  logic [W2-DATA_WIDTH:0] top_bits;
  logic [DATA_WIDTH-1:0] prod_next;
  logic                  ovf_next;

  // Operand magnitudes; negating the most negative value yields 2^(W-1) as unsigned.
  always_comb begin
    abs_a = a[DATA_WIDTH-1] ? -a : a;
    abs_b = b[DATA_WIDTH-1] ? -b : b;
  end

  // Sign fix-up, floor scaling and range check of the finished magnitude product.
  always_comb begin
    signed_full = sign_q ? -acc : acc;
    shifted     = $signed(signed_full) >>> BIN_POS;
    top_bits    = shifted[W2-1:DATA_WIDTH-1];
    ovf_next    = !((&top_bits) || !(|top_bits));
    prod_next   = shifted[DATA_WIDTH-1:0];
`ifdef SEQ_FIXED_MUL_SATURATE_EN
    if (ovf_next) prod_next = sign_q ? SAT_MIN : SAT_MAX;
`endif
  end

  // Sequencer and shift-add datapath with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ready    <= 1'b0;
      complete <= 1'b0;
      prod     <= '0;
      overflow <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          ready <= 1'b1;
          if (start) begin
            sign_q   <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
            mcand    <= W2'(abs_a);
            mplier   <= abs_b;
            acc      <= '0;
            cnt      <= '0;
            ready    <= 1'b0;
            complete <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(DATA_WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          prod     <= prod_next;
          overflow <= ovf_next;
          complete <= 1'b1;
          ready    <= 1'b1;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
